pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/buceros_header.v | 16 +
 rtl/pipe_ctrl_sat_counter.sv | 27 ++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Types and constants shared by the pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`include "buceros_header.v"
`default_nettype none

package pipe_ctrl_pkg;

    localparam int c_wd_w = 16;

    typedef enum logic [1:0] {
        ST_RUN      = `PCTRL_RUN,
        ST_MEM_WAIT = `PCTRL_MEM_WAIT,
        ST_REDIRECT = `PCTRL_REDIRECT
    } pctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/buceros_header.v
// ============================================================================
// Module      : buceros_header (shared defines)
// Description : Core-wide address widths and pipeline-controller state codes.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef BUCEROS_HEADER_V
`define BUCEROS_HEADER_V

`define REG_ADDR_W      5
`define INST_ADDR_W     32

`define PCTRL_RUN       2'd0
`define PCTRL_MEM_WAIT  2'd1
`define PCTRL_REDIRECT  2'd2

`endif

// File: rtl/pipe_ctrl_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : 5-stage pipeline hazard/stall/flush controller with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`include "buceros_header.v"
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`REG_ADDR_W-1:0]  id_rs1_addr_i,
    input  logic [`REG_ADDR_W-1:0]  id_rs2_addr_i,
    input  logic                    id_rs1_used_i,
    input  logic                    id_rs2_used_i,
    input  logic                    ex_rmem_en_i,
    input  logic [`REG_ADDR_W-1:0]  ex_wreg_addr_i,
    input  logic                    id_branch_i,
    input  logic [`INST_ADDR_W-1:0] id_target_i,
    input  logic                    if_busy_i,
    input  logic                    mem_busy_i,
    output logic                    stall_if_o,
    output logic                    stall_id_o,
    output logic                    stall_ex_o,
    output logic                    stall_mem_o,
    output logic                    flush_id_o,
    output logic                    flush_ex_o,
    output logic                    redirect_o,
    output logic [`INST_ADDR_W-1:0] redirect_addr_o,
    output logic                    err_timeout_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        flush_cnt_o
);

    pctrl_state_t            r_state;
    logic [`INST_ADDR_W-1:0] r_target;
    logic [c_wd_w-1:0]       r_wd;
    logic                    r_err;

    logic                    w_load_use;
    logic                    w_wd_hit;
    logic [CNT_W-1:0]        w_stall_cnt;
    logic [CNT_W-1:0]        w_flush_cnt;

    assign w_load_use = ex_rmem_en_i && (ex_wreg_addr_i != '0) &&
                        ((id_rs1_used_i && (id_rs1_addr_i == ex_wreg_addr_i)) ||
                         (id_rs2_used_i && (id_rs2_addr_i == ex_wreg_addr_i)));

    // Fires during the TIMEOUT_CYC-th consecutive MEM_WAIT cycle so the flag is visible immediately.
    assign w_wd_hit = (r_state == ST_MEM_WAIT) && (r_wd == c_wd_w'(TIMEOUT_CYC - 1));

    always_comb begin
        stall_if_o      = 1'b0;
        stall_id_o      = 1'b0;
        stall_ex_o      = 1'b0;
        stall_mem_o     = 1'b0;
        flush_id_o      = 1'b0;
        flush_ex_o      = 1'b0;
        redirect_o      = 1'b0;
        redirect_addr_o = '0;
        if (!rst) begin
            if (mem_busy_i) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                stall_ex_o  = 1'b1;
                stall_mem_o = 1'b1;
            end else if (r_state == ST_REDIRECT) begin
                redirect_o      = 1'b1;
                redirect_addr_o = r_target;
                flush_id_o      = 1'b1;
            end else if (w_load_use) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                flush_ex_o = 1'b1;
            end else if (id_branch_i) begin
                redirect_o      = 1'b1;
                redirect_addr_o = id_target_i;
                flush_id_o      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_target <= '0;
            r_wd     <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_wd_hit) begin
                r_err <= 1'b1;
            end
            if (r_state == ST_MEM_WAIT) begin
                if (r_wd != {c_wd_w{1'b1}}) begin
                    r_wd <= r_wd + {{(c_wd_w-1){1'b0}}, 1'b1};
                end
            end else begin
                r_wd <= '0;
            end
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_busy_i) begin
                        r_state <= ST_MEM_WAIT;
                    end else if (!w_load_use && id_branch_i && if_busy_i) begin
                        r_state  <= ST_REDIRECT;
                        r_target <= id_target_i;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    if (!if_busy_i && !mem_busy_i) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_id_o),
        .cnt (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_id_o | flush_ex_o),
        .cnt (w_flush_cnt)
    );

    assign err_timeout_o = !rst && (r_err || w_wd_hit);
    assign stall_cnt_o   = rst ? '0 : w_stall_cnt;
    assign flush_cnt_o   = rst ? '0 : w_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard bench for pipe_ctrl (TIMEOUT_CYC=4, CNT_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_wreg_addr_i;
    logic        id_rs1_used_i, id_rs2_used_i, ex_rmem_en_i;
    logic        id_branch_i, if_busy_i, mem_busy_i;
    logic [31:0] id_target_i;
    logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic        flush_id_o, flush_ex_o, redirect_o, err_timeout_o;
    logic [31:0] redirect_addr_o;
    logic [2:0]  stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT_CYC(4), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .id_rs1_used_i   (id_rs1_used_i),
        .id_rs2_used_i   (id_rs2_used_i),
        .ex_rmem_en_i    (ex_rmem_en_i),
        .ex_wreg_addr_i  (ex_wreg_addr_i),
        .id_branch_i     (id_branch_i),
        .id_target_i     (id_target_i),
        .if_busy_i       (if_busy_i),
        .mem_busy_i      (mem_busy_i),
        .stall_if_o      (stall_if_o),
        .stall_id_o      (stall_id_o),
        .stall_ex_o      (stall_ex_o),
        .stall_mem_o     (stall_mem_o),
        .flush_id_o      (flush_id_o),
        .flush_ex_o      (flush_ex_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .err_timeout_o   (err_timeout_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        ld;
        logic [4:0]  wa;
        logic        br;
        logic [31:0] tgt;
        logic        ifb;
        logic        memb;
        logic        rst;
    } in_t;

    typedef struct {
        logic [3:0]  st;   // {if,id,ex,mem}
        logic [1:0]  fl;   // {id,ex}
        logic        rd;
        logic [31:0] ra;
        logic        err;
        logic [2:0]  sc;
        logic [2:0]  fc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input in_t v, input logic [3:0] st, input logic [1:0] fl,
                        input logic rd, input logic [31:0] ra, input logic err,
                        input logic [2:0] sc, input logic [2:0] fc, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = v.rst;
        id_rs1_addr_i  = v.rs1;
        id_rs2_addr_i  = v.rs2;
        id_rs1_used_i  = v.u1;
        id_rs2_used_i  = v.u2;
        ex_rmem_en_i   = v.ld;
        ex_wreg_addr_i = v.wa;
        id_branch_i    = v.br;
        id_target_i    = v.tgt;
        if_busy_i      = v.ifb;
        mem_busy_i     = v.memb;
        e.st = st; e.fl = fl; e.rd = rd; e.ra = ra;
        e.err = err; e.sc = sc; e.fc = fc; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: every expected entry covers one cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({stall_if_o, stall_id_o, stall_ex_o, stall_mem_o} !== e.st ||
                    {flush_id_o, flush_ex_o} !== e.fl || redirect_o !== e.rd ||
                    redirect_addr_o !== e.ra || err_timeout_o !== e.err ||
                    stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
                    errors++;
                    $display("FAIL %s: got st=%b fl=%b rd=%b addr=%h err=%b sc=%0d fc=%0d, expected st=%b fl=%b rd=%b addr=%h err=%b sc=%0d fc=%0d",
                             e.nm, {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o},
                             {flush_id_o, flush_ex_o}, redirect_o, redirect_addr_o,
                             err_timeout_o, stall_cnt_o, flush_cnt_o,
                             e.st, e.fl, e.rd, e.ra, e.err, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        in_t v;
        int  k;
        rst = 1'b1;
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_wreg_addr_i = '0;
        id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; ex_rmem_en_i = 1'b0;
        id_branch_i = 1'b0; if_busy_i = 1'b0; mem_busy_i = 1'b0; id_target_i = '0;

        // Reset cycle with busy inputs: everything must read zero
        v = '0; v.rst = 1; v.memb = 1; v.br = 1; v.tgt = 32'h40; v.ifb = 1;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd0, 3'd0, "reset");

        // Load-use on rs1 with a branch present (branch ignored)
        v = '0; v.ld = 1; v.wa = 5; v.rs1 = 5; v.u1 = 1; v.br = 1; v.tgt = 32'h40;
        step(v, 4'b1100, 2'b01, 0, 32'h0, 0, 3'd0, 3'd0, "load_use_rs1");
        v = '0;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd1, 3'd1, "after_load_use");

        // Load to x0 never stalls
        v = '0; v.ld = 1; v.wa = 0; v.rs1 = 0; v.u1 = 1; v.rs2 = 0; v.u2 = 1;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd1, 3'd1, "x0_no_stall");
        // rs2 matches but is not used
        v = '0; v.ld = 1; v.wa = 7; v.rs1 = 3; v.u1 = 1; v.rs2 = 7; v.u2 = 0;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd1, 3'd1, "rs2_unused");
        v.u2 = 1;
        step(v, 4'b1100, 2'b01, 0, 32'h0, 0, 3'd1, 3'd1, "load_use_rs2");

        // Immediate branch, fetch ready
        v = '0; v.br = 1; v.tgt = 32'h0000_0100;
        step(v, 4'b0000, 2'b10, 1, 32'h100, 0, 3'd2, 3'd2, "branch");
        v = '0; v.tgt = 32'h200;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd2, 3'd3, "after_branch");

        // Delayed redirect, latched address survives target changes
        v = '0; v.rst = 1;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd0, 3'd0, "reset2");
        v = '0; v.br = 1; v.tgt = 32'h300; v.ifb = 1;
        step(v, 4'b0000, 2'b10, 1, 32'h300, 0, 3'd0, 3'd0, "redir_c1");
        v.tgt = 32'h444;
        step(v, 4'b0000, 2'b10, 1, 32'h300, 0, 3'd0, 3'd1, "redir_c2");
        v.br = 0; v.tgt = 32'h555;
        step(v, 4'b0000, 2'b10, 1, 32'h300, 0, 3'd0, 3'd2, "redir_c3");
        v.br = 1; v.tgt = 32'h666; v.ifb = 0;
        step(v, 4'b0000, 2'b10, 1, 32'h300, 0, 3'd0, 3'd3, "redir_c4");
        v = '0; v.tgt = 32'h666;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd0, 3'd4, "redir_done");

        // Memory wait of 5 cycles, watchdog fires in 4th MEM_WAIT cycle
        v = '0; v.memb = 1; v.br = 1; v.tgt = 32'h800; v.ld = 1; v.wa = 2; v.rs1 = 2; v.u1 = 1;
        step(v, 4'b1111, 2'b00, 0, 32'h0, 0, 3'd0, 3'd4, "mem_c1");
        step(v, 4'b1111, 2'b00, 0, 32'h0, 0, 3'd1, 3'd4, "mem_c2");
        step(v, 4'b1111, 2'b00, 0, 32'h0, 0, 3'd2, 3'd4, "mem_c3");
        step(v, 4'b1111, 2'b00, 0, 32'h0, 0, 3'd3, 3'd4, "mem_c4");
        step(v, 4'b1111, 2'b00, 0, 32'h0, 1, 3'd4, 3'd4, "mem_c5");
        v = '0;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd5, 3'd4, "mem_exit");
        step(v, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd5, 3'd4, "err_sticky");

        // Reset in the middle of a pending redirect
        v = '0; v.br = 1; v.tgt = 32'h700; v.ifb = 1;
        step(v, 4'b0000, 2'b10, 1, 32'h700, 1, 3'd5, 3'd4, "redir_pre_rst");
        v = '0; v.rst = 1; v.ifb = 1;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd0, 3'd0, "rst_mid_redir");
        v = '0; v.ifb = 1;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd0, 3'd0, "redir_dropped");

        // Counter saturation with 9 consecutive load-use cycles
        v = '0; v.ld = 1; v.wa = 9; v.rs2 = 9; v.u2 = 1;
        for (int i = 1; i <= 9; i++) begin
            k = (i - 1 > 7) ? 7 : i - 1;
            step(v, 4'b1100, 2'b01, 0, 32'h0, 0, 3'(k), 3'(k), "saturate");
        end
        v = '0;
        step(v, 4'b0000, 2'b00, 0, 32'h0, 0, 3'd7, 3'd7, "saturated");

        k = 0;
        while (sb.size() > 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
